// File: rtl/riscv_dcache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_dcache_pkg                                             |
// | Description : Shared state encoding and address-split constants.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package riscv_dcache_pkg;

    localparam int c_OFFSET_BITS    = 4;
    localparam int c_WORD_SEL_BITS  = 2;
    localparam int c_WORD_BITS      = 32;
    localparam int c_DEF_LINES      = 64;
    localparam int c_DEF_LINE_BITS  = 128;
    localparam int c_DEF_ADDR_BITS  = 32;
    localparam int c_LINE_ADDR_BITS = c_DEF_ADDR_BITS - c_OFFSET_BITS;
    localparam int c_INDEX_BITS     = $clog2(c_DEF_LINES);
    localparam int c_TAG_BITS       = c_LINE_ADDR_BITS - c_INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB_REQ  = 3'd1,
        S_RF_REQ  = 3'd2,
        S_RF_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_dcache_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_dcache_array                                           |
// | Description : Valid/dirty/tag/data storage, async read, byte-enable write. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module riscv_dcache_array #(
    parameter int LINES     = 64,
    parameter int LINE_BITS = 128,
    parameter int TAG_BITS  = 22,
    parameter int IDX_BITS  = $clog2(LINES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IDX_BITS-1:0]    i_rd_idx,
    output logic                   o_rd_valid,
    output logic                   o_rd_dirty,
    output logic [TAG_BITS-1:0]    o_rd_tag,
    output logic [LINE_BITS-1:0]   o_rd_line,
    input  logic                   i_wr_en,
    input  logic [IDX_BITS-1:0]    i_wr_idx,
    input  logic [LINE_BITS/8-1:0] i_wr_be,
    input  logic [LINE_BITS-1:0]   i_wr_line,
    input  logic [TAG_BITS-1:0]    i_wr_tag,
    input  logic                   i_wr_dirty
);

    logic [LINES-1:0]     r_valid;
    logic [LINES-1:0]     r_dirty;
    logic [TAG_BITS-1:0]  r_tag  [LINES];
    logic [LINE_BITS-1:0] r_data [LINES];

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_line  = r_data[i_rd_idx];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= 1'b1;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    // Tag and data have no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx] <= i_wr_tag;
            for (int b = 0; b < LINE_BITS/8; b++) begin
                if (i_wr_be[b]) begin
                    r_data[i_wr_idx][b*8 +: 8] <= i_wr_line[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_dcache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : riscv_dcache                                                 |
// | Description : Direct-mapped write-back write-allocate data cache.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module riscv_dcache
    import riscv_dcache_pkg::*;
#(
    parameter int LINES     = c_DEF_LINES,
    parameter int LINE_BITS = c_DEF_LINE_BITS,
    parameter int ADDR_BITS = c_DEF_ADDR_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_BITS-1:0]               dcache_addr,
    input  logic                               dcache_re,
    input  logic [3:0]                         dcache_we,
    input  logic [c_WORD_BITS-1:0]             dcache_din,
    output logic [c_WORD_BITS-1:0]             dcache_dout,
    output logic                               stall,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic                               mem_req_rw,
    output logic [ADDR_BITS-c_OFFSET_BITS-1:0] mem_req_addr,
    output logic                               mem_req_data_valid,
    input  logic                               mem_req_data_ready,
    output logic [LINE_BITS-1:0]               mem_req_data_bits,
    output logic [LINE_BITS/8-1:0]             mem_req_data_mask,
    input  logic                               mem_resp_valid,
    input  logic [LINE_BITS-1:0]               mem_resp_data
);

    localparam int c_IDX_W  = $clog2(LINES);
    localparam int c_TAG_W  = ADDR_BITS - c_OFFSET_BITS - c_IDX_W;
    localparam int c_NBYTES = LINE_BITS / 8;
    localparam int c_NWORDS = LINE_BITS / c_WORD_BITS;

    state_t                     r_state, w_state_nxt;
    logic                       r_req_pending;
    logic [ADDR_BITS-1:0]       r_req_addr;
    logic [3:0]                 r_req_we;
    logic [c_WORD_BITS-1:0]     r_req_din;
    logic                       r_cmd_sent, r_data_sent;
    logic [c_WORD_BITS-1:0]     r_dout;

    logic [c_IDX_W-1:0]         w_idx;
    logic [c_TAG_W-1:0]         w_tag;
    logic [c_WORD_SEL_BITS-1:0] w_wsel;
    logic                       w_rd_valid, w_rd_dirty;
    logic [c_TAG_W-1:0]         w_rd_tag;
    logic [LINE_BITS-1:0]       w_rd_line;
    logic                       w_wr_en, w_wr_dirty;
    logic [c_NBYTES-1:0]        w_wr_be;
    logic [LINE_BITS-1:0]       w_wr_line, w_merged;
    logic                       w_accept, w_lookup, w_hit, w_is_write;
    logic                       w_read_done, w_cmd_done, w_data_done, w_stall;
    logic [c_WORD_BITS-1:0]     w_word;
    logic                       w_unused_ok;

    assign w_idx       = r_req_addr[c_OFFSET_BITS +: c_IDX_W];
    assign w_tag       = r_req_addr[ADDR_BITS-1 -: c_TAG_W];
    assign w_wsel      = r_req_addr[c_OFFSET_BITS-1:2];
    assign w_unused_ok = &{1'b0, r_req_addr[1:0]};

    assign w_is_write  = |r_req_we;
    assign w_lookup    = (r_state == S_IDLE) && r_req_pending;
    assign w_hit       = w_rd_valid && (w_rd_tag == w_tag);
    assign w_accept    = (dcache_re || (|dcache_we)) && !w_stall;
    assign w_word      = w_rd_line[w_wsel*c_WORD_BITS +: c_WORD_BITS];

    assign stall             = w_stall;
    assign dcache_dout       = w_read_done ? w_word : r_dout;
    assign mem_req_data_bits = w_rd_line;
    assign mem_req_data_mask = '1;

    riscv_dcache_array #(
        .LINES     (LINES),
        .LINE_BITS (LINE_BITS),
        .TAG_BITS  (c_TAG_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_rd_idx   (w_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_line  (w_rd_line),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_idx),
        .i_wr_be    (w_wr_be),
        .i_wr_line  (w_wr_line),
        .i_wr_tag   (w_tag),
        .i_wr_dirty (w_wr_dirty)
    );

    // Refill line with the pending store folded in, so a write miss completes in one edge.
    always_comb begin
        w_merged = mem_resp_data;
        for (int b = 0; b < 4; b++) begin
            if (r_req_we[b]) begin
                w_merged[w_wsel*c_WORD_BITS + b*8 +: 8] = r_req_din[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_stall            = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = {w_tag, w_idx};
        mem_req_data_valid = 1'b0;
        w_wr_en            = 1'b0;
        w_wr_be            = '0;
        w_wr_line          = {c_NWORDS{r_req_din}};
        w_wr_dirty         = 1'b1;
        w_read_done        = 1'b0;
        w_cmd_done         = 1'b0;
        w_data_done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_lookup) begin
                    if (w_hit) begin
                        w_read_done = !w_is_write;
                        if (w_is_write) begin
                            w_wr_en = 1'b1;
                            w_wr_be[w_wsel*4 +: 4] = r_req_we;
                        end
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = (w_rd_valid && w_rd_dirty) ? S_WB_REQ : S_RF_REQ;
                    end
                end
            end
            S_WB_REQ: begin
                w_stall            = 1'b1;
                mem_req_rw         = 1'b1;
                mem_req_addr       = {w_rd_tag, w_idx};
                mem_req_valid      = !r_cmd_sent;
                mem_req_data_valid = !r_data_sent;
                w_cmd_done         = r_cmd_sent  || mem_req_ready;
                w_data_done        = r_data_sent || mem_req_data_ready;
                if (w_cmd_done && w_data_done) begin
                    w_state_nxt = S_RF_REQ;
                end
            end
            S_RF_REQ: begin
                w_stall       = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_nxt = S_RF_WAIT;
                end
            end
            S_RF_WAIT: begin
                w_stall = 1'b1;
                if (mem_resp_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_be     = '1;
                    w_wr_line   = w_merged;
                    w_wr_dirty  = w_is_write;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_read_done = !w_is_write;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_req_pending <= 1'b0;
            r_cmd_sent    <= 1'b0;
            r_data_sent   <= 1'b0;
            r_dout        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req_pending <= 1'b1;
            end else if ((w_lookup && w_hit) || (r_state == S_DONE)) begin
                r_req_pending <= 1'b0;
            end
            if ((r_state == S_WB_REQ) && (w_state_nxt == S_WB_REQ)) begin
                r_cmd_sent  <= w_cmd_done;
                r_data_sent <= w_data_done;
            end else begin
                r_cmd_sent  <= 1'b0;
                r_data_sent <= 1'b0;
            end
            if (w_read_done) begin
                r_dout <= w_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req_addr <= dcache_addr;
            r_req_we   <= dcache_we;
            r_req_din  <= dcache_din;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_dcache.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_riscv_dcache                                              |
// | Description : Directed table, corner sequences and random traffic checks.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_riscv_dcache;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  dcache_addr = '0;
    logic         dcache_re = 1'b0;
    logic [3:0]   dcache_we = '0;
    logic [31:0]  dcache_din = '0;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic         mem_req_data_valid;
    logic         mem_req_data_ready = 1'b0;
    logic [127:0] mem_req_data_bits;
    logic [15:0]  mem_req_data_mask;
    logic         mem_resp_valid = 1'b0;
    logic [127:0] mem_resp_data = '0;

    always #5 clk = ~clk;

    riscv_dcache dut (
        .clk                (clk),
        .reset              (reset),
        .dcache_addr        (dcache_addr),
        .dcache_re          (dcache_re),
        .dcache_we          (dcache_we),
        .dcache_din         (dcache_din),
        .dcache_dout        (dcache_dout),
        .stall              (stall),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: which line each set holds, plus architectural memory contents.
    logic         m_v [64];
    logic         m_d [64];
    logic [21:0]  m_t [64];
    logic [127:0] backing [logic [27:0]];
    logic [127:0] gold    [logic [27:0]];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        bit          hit;
        bit          wb;
        logic [31:0] dout;
        int          cmd_dly;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        if (backing.exists(la)) return backing[la];
        return {la, 4'h3, la, 4'h2, la, 4'h1, la, 4'h0};
    endfunction

    function automatic logic [127:0] gold_line(input logic [27:0] la);
        if (gold.exists(la)) return gold[la];
        return mem_line(la);
    endfunction

    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                          input bit exp_hit, input bit exp_wb, input logic [31:0] exp_dout,
                          input int cmd_dly, input int dat_dly, input int resp_dly);
        int           idx = int'(a[9:4]);
        int           w = int'(a[3:2]);
        logic [27:0]  la = a[31:4];
        logic [27:0]  wb_la = {m_t[idx], a[9:4]};
        logic [127:0] wb_line = gold_line({m_t[idx], a[9:4]});
        logic [127:0] line;
        bit           rd = (we == 4'b0);
        bit           fin = 0, stab_bad = 0, wbc_seen = 0, wbd_seen = 0, rf_seen = 0;
        bit           wbc_done = 0, wbd_done = 0, resp_sent = 0;
        int           wbc = 0, wbd = 0, rf_acc = -1;
        @(negedge clk);
        dcache_addr = a; dcache_re = rd; dcache_we = we; dcache_din = din;
        @(negedge clk);
        dcache_re = 1'b0; dcache_we = 4'b0;
        check("lookup_stall", stall, !exp_hit);
        if (exp_hit) begin
            if (rd) check("hit_dout", dcache_dout, exp_dout);
            check("hit_no_mem", mem_req_valid | mem_req_data_valid, 0);
        end else begin
            for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
                @(negedge clk);
                mem_req_ready = 1'b0; mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0;
                if (!stall) begin
                    fin = 1;
                    if (rd) check("miss_dout", dcache_dout, exp_dout);
                    check("refilled", resp_sent, 1);
                    check("req_stable", stab_bad, 0);
                    if (exp_wb) check("wb_complete", wbc_done & wbd_done, 1);
                end else begin
                    if (mem_req_valid && mem_req_rw) begin
                        if (!wbc_seen) begin
                            wbc_seen = 1;
                            check("wb_expected", 1, exp_wb);
                            check("wb_addr", mem_req_addr, wb_la);
                        end else if (mem_req_addr != wb_la) stab_bad = 1;
                        if (wbc >= cmd_dly) begin mem_req_ready = 1'b1; wbc_done = 1; end
                        wbc++;
                    end
                    if (mem_req_data_valid) begin
                        if (!wbd_seen) begin
                            wbd_seen = 1;
                            check("wb_data", mem_req_data_bits, wb_line);
                            check("wb_mask", mem_req_data_mask, 16'hFFFF);
                        end else if (mem_req_data_bits != wb_line) stab_bad = 1;
                        if (wbd >= dat_dly) begin
                            mem_req_data_ready = 1'b1; wbd_done = 1;
                            backing[wb_la] = mem_req_data_bits;
                        end
                        wbd++;
                    end
                    if (mem_req_valid && !mem_req_rw && !rf_seen) begin
                        rf_seen = 1;
                        check("rf_addr", mem_req_addr, la);
                        check("rf_after_wb", wbc_done & wbd_done, exp_wb);
                        mem_req_ready = 1'b1;
                        rf_acc = cyc;
                    end
                    if (rf_acc >= 0 && !resp_sent && cyc >= rf_acc + 1 + resp_dly) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = mem_line(la);
                        resp_sent = 1;
                    end
                end
            end
            if (!fin) check("miss_timeout", 0, 1);
        end
        if (!exp_hit) m_d[idx] = 1'b0;
        m_v[idx] = 1'b1;
        m_t[idx] = a[31:10];
        if (!rd) begin
            line = gold_line(la);
            for (int b = 0; b < 4; b++)
                if (we[b]) line[w*32 + b*8 +: 8] = din[b*8 +: 8];
            gold[la] = line;
            m_d[idx] = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0]  a, ed, din;
        logic [3:0]   we;
        logic [127:0] ln;
        int           idx, w;
        bit           hit, wb;

        for (int i = 0; i < 64; i++) begin m_v[i] = 0; m_d[i] = 0; m_t[i] = '0; end
        backing[28'h0000100] = 128'h44443333_22221111_0000FFFF_12345678;
        backing[28'h0000200] = 128'hDDDD4444_CCCC3333_BBBB2222_AAAA1111;

        tbl[0] = '{32'h0000_1004, 4'b0000, 32'h0,         0, 0, 32'h0000FFFF, 0};
        tbl[1] = '{32'h0000_1008, 4'b0000, 32'h0,         1, 0, 32'h22221111, 0};
        tbl[2] = '{32'h0000_1000, 4'b0010, 32'h0000AB00, 1, 0, 32'h0,        0};
        tbl[3] = '{32'h0000_1000, 4'b0000, 32'h0,         1, 0, 32'h1234AB78, 0};
        tbl[4] = '{32'h0000_2000, 4'b0000, 32'h0,         0, 1, 32'hAAAA1111, 5};
        tbl[5] = '{32'h0000_1000, 4'b0000, 32'h0,         0, 0, 32'h1234AB78, 0};

        repeat (3) @(negedge clk);
        check("rst_stall", stall, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_data_valid", mem_req_data_valid, 0);
        check("rst_dout", dcache_dout, 0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++)
            access(tbl[i].addr, tbl[i].we, tbl[i].din, tbl[i].hit, tbl[i].wb, tbl[i].dout,
                   tbl[i].cmd_dly, 0, 1);

        // Back-to-back hits: second request is accepted during the first lookup.
        @(negedge clk); dcache_addr = 32'h0000_1004; dcache_re = 1'b1;
        @(negedge clk);
        check("b2b_first", dcache_dout, 32'h0000FFFF);
        check("b2b_first_stall", stall, 0);
        dcache_addr = 32'h0000_100C;
        @(negedge clk); dcache_re = 1'b0;
        check("b2b_second", dcache_dout, 32'h44443333);
        check("b2b_second_stall", stall, 0);

        // Reset while waiting for refill; the late response must be ignored.
        @(negedge clk); dcache_addr = 32'h0000_3000; dcache_re = 1'b1;
        @(negedge clk); dcache_re = 1'b0;
        check("rstseq_miss", stall, 1);
        @(negedge clk);
        check("rstseq_rf_req", {mem_req_valid, mem_req_rw}, 2'b10);
        check("rstseq_rf_addr", mem_req_addr, 28'h0000300);
        mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0; reset = 1'b0;
        @(negedge clk); reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = '1;
        check("rstseq_stall", stall, 0);
        check("rstseq_req_valid", mem_req_valid, 0);
        @(negedge clk); mem_resp_valid = 1'b0;
        check("rstseq_stall_after_resp", stall, 0);
        check("rstseq_valids_after_resp", mem_req_valid | mem_req_data_valid, 0);
        check("rstseq_dout", dcache_dout, 0);
        for (int i = 0; i < 64; i++) begin m_v[i] = 0; m_d[i] = 0; end
        gold.delete();
        ln = mem_line(28'h0000300);
        access(32'h0000_3000, 4'b0, 32'h0, 0, 0, ln[31:0], 0, 0, 0);

        for (int n = 0; n < 200; n++) begin
            a   = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            we  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            din = $urandom;
            idx = int'(a[9:4]);
            w   = int'(a[3:2]);
            hit = m_v[idx] && (m_t[idx] == a[31:10]);
            wb  = !hit && m_v[idx] && m_d[idx];
            ln  = gold_line(a[31:4]);
            ed  = ln[w*32 +: 32];
            access(a, we, din, hit, wb, ed,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
